// File: rtl/queue_pkg.sv
// Shared helpers for the queue controller: pointer/count widths, one-hot row
// decode and the arbiter grant encoding.
package queue_pkg;

  // Widest row-select bus the one-hot helper can produce; callers cast down.
  localparam int ONEHOT_MAX = 64;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PUSH = 2'd1,
    GNT_POP  = 2'd2
  } grant_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned index);
    logic [ONEHOT_MAX-1:0] vec;
    vec = '0;
    if (index < ONEHOT_MAX) vec[index] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrap-around pointer register for a queue of DEPTH words; the wrap is an
// explicit compare so non-power-of-two depths work.
module queue_ptr
  import queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int W     = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queue_ctrl.sv
// Queue sequencer/arbiter: owns pointers, occupancy and error flags, and grants
// at most one push or pop per cycle onto the shared RowSelect bus.
module queue_ctrl
  import queue_pkg::*;
#(
  parameter  int Column     = 4,
  parameter  int bitPerWord = 8,
  localparam int PTR_W      = ptr_w(Column),
  localparam int CNT_W      = cnt_w(Column)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  output logic              push_ack,
  output logic              pop_ack,
  output logic [Column-1:0] RowSelect,
  output logic              WriteEn,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  // Only elaborates for an illegal parameter set, leaving an obvious marker.
  if (Column < 2 || Column > ONEHOT_MAX || bitPerWord < 1) begin : g_bad_params
    logic bad_params;
    assign bad_params = 1'b1;
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_push_q, last_push_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_req, pop_req;
  grant_e           grant;

  assign full     = (count_q == CNT_W'(Column));
  assign empty    = (count_q == '0);
  assign push_req = push & ~full;
  assign pop_req  = pop & ~empty;

  // Gating on rst keeps the memory from seeing a write while reset is held.
  always_comb begin
    grant = GNT_NONE;
    if (!clear && !rst) begin
      if (push_req && pop_req) grant = last_push_q ? GNT_POP : GNT_PUSH;
      else if (push_req)       grant = GNT_PUSH;
      else if (pop_req)        grant = GNT_POP;
    end
  end

  always_comb begin
    count_d     = count_q;
    last_push_d = last_push_q;
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
    if (clear) begin
      count_d     = '0;
      last_push_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_req && pop_req) last_push_d = (grant == GNT_PUSH);
      unique case (grant)
        GNT_PUSH: count_d = count_q + CNT_W'(1);
        GNT_POP:  count_d = count_q - CNT_W'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      last_push_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      last_push_q <= last_push_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  queue_ptr #(.DEPTH(Column)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (grant == GNT_PUSH),
    .ptr (wr_ptr)
  );

  queue_ptr #(.DEPTH(Column)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (grant == GNT_POP),
    .ptr (rd_ptr)
  );

  // Head row is selected whenever not writing, so DataOut always shows it.
  assign RowSelect = (grant == GNT_PUSH) ? Column'(onehot(int'(wr_ptr)))
                                         : Column'(onehot(int'(rd_ptr)));
  assign push_ack  = (grant == GNT_PUSH);
  assign WriteEn   = (grant == GNT_PUSH);
  assign pop_ack   = (grant == GNT_POP);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl: directed plan followed by random traffic,
// compared against a queue-based behavioural model.
module tb_queue_ctrl;

  localparam int C  = 4;
  localparam int CW = $clog2(C + 1);

  logic          clk;
  logic          rst;
  logic          push, pop, clear;
  logic          push_ack, pop_ack, WriteEn, full, empty, overflow, underflow;
  logic [C-1:0]  RowSelect;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  // Model: contents as a queue of row numbers, plus totals since last reset.
  int m_rows[$];
  int m_push_total, m_pop_total;
  bit m_last_push, m_ovf, m_unf;

  queue_ctrl #(.Column(C), .bitPerWord(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_ack  (push_ack),
    .pop_ack   (pop_ack),
    .RowSelect (RowSelect),
    .WriteEn   (WriteEn),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rows.delete();
    m_push_total = 0;
    m_pop_total  = 0;
    m_last_push  = 0;
    m_ovf        = 0;
    m_unf        = 0;
  endtask

  // Expected grant for the current inputs: 0 none, 1 push, 2 pop.
  function automatic int model_grant(input bit p, input bit q, input bit c);
    bit pe, qe;
    pe = p && (m_rows.size() < C);
    qe = q && (m_rows.size() > 0);
    if (c) return 0;
    if (pe && qe) return m_last_push ? 2 : 1;
    if (pe) return 1;
    if (qe) return 2;
    return 0;
  endfunction

  task automatic check_state(input string ph, input int g);
    logic [C-1:0] exp_row;
    exp_row = (g == 1) ? C'(1 << (m_push_total % C)) : C'(1 << (m_pop_total % C));
    chk({ph, ".push_ack"},  32'(push_ack),  32'(g == 1));
    chk({ph, ".WriteEn"},   32'(WriteEn),   32'(g == 1));
    chk({ph, ".pop_ack"},   32'(pop_ack),   32'(g == 2));
    chk({ph, ".RowSelect"}, 32'(RowSelect), 32'(exp_row));
    chk({ph, ".count"},     32'(count),     32'(m_rows.size()));
    chk({ph, ".full"},      32'(full),      32'(m_rows.size() == C));
    chk({ph, ".empty"},     32'(empty),     32'(m_rows.size() == 0));
    chk({ph, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({ph, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // One cycle: drive, check mid-cycle, let the edge happen, advance the model.
  task automatic step(input string ph, input bit p, input bit q, input bit c);
    int g;
    bit conflict;
    push = p; pop = q; clear = c;
    @(negedge clk);
    g = model_grant(p, q, c);
    check_state(ph, g);
    $display("step %-8s push=%0b pop=%0b clear=%0b -> push_ack=%0b pop_ack=%0b row=%b count=%0d",
             ph, p, q, c, push_ack, pop_ack, RowSelect, count);
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      conflict = p && q && (m_rows.size() < C) && (m_rows.size() > 0);
      if (p && m_rows.size() == C) m_ovf = 1;
      if (q && m_rows.size() == 0) m_unf = 1;
      if (conflict) m_last_push = (g == 1);
      if (g == 1) begin
        m_rows.push_back(m_push_total % C);
        m_push_total++;
      end else if (g == 2) begin
        void'(m_rows.pop_front());
        m_pop_total++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.WriteEn_held", 32'(WriteEn), 32'd0);
    rst = 1'b0;

    step("idle", 0, 0, 0);
    repeat (4) step("fill", 1, 0, 0);
    step("ovf", 1, 0, 0);
    repeat (4) step("drain", 0, 1, 0);
    step("unf", 0, 1, 0);
    repeat (10) step("wrap", 1, 1, 0);
    repeat (4) step("wrapdrn", 0, 1, 0);

    step("clr0", 0, 0, 1);
    repeat (2) step("pre2", 1, 0, 0);
    repeat (4) step("alt", 1, 1, 0);

    step("clr1", 0, 0, 1);
    repeat (5) step("fill3", 1, 0, 0);
    step("pop3", 0, 1, 0);
    step("clrwr", 1, 0, 1);
    step("aftclr", 0, 0, 0);

    // Asynchronous reset between edges with two words held and a push pending.
    repeat (2) step("pre_rst", 1, 0, 0);
    push = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.count",     32'(count),     32'd0);
    chk("arst.empty",     32'(empty),     32'd1);
    chk("arst.full",      32'(full),      32'd0);
    chk("arst.WriteEn",   32'(WriteEn),   32'd0);
    chk("arst.push_ack",  32'(push_ack),  32'd0);
    chk("arst.RowSelect", 32'(RowSelect), 32'd1);
    $display("async rst: count=%0d empty=%0b WriteEn=%0b row=%b", count, empty, WriteEn, RowSelect);
    push = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step("postrst", 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Sequencer and arbiter for the queue memory block, a Column-deep array of bitPerWord-bit word cells sharing one DataIn, one DataOut, a one-hot RowSelect and a single WriteEn.
- Owns the write and read pointers, occupancy, and full/empty.
- Arbitrates push and pop requesters onto the single RowSelect bus, one operation per cycle, with alternating priority on conflict.
- The memory block sits directly behind it; the queue top wires RowSelect/WriteEn straight through.

Parameters:
- Column, 4, queue depth in words; integer >= 2; need not be a power of two.
- bitPerWord, 8, word width; used only by the top-level wrapper, carried here for consistency.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push requester wants to write DataIn this cycle.
- pop  input  1  pop requester wants to consume the head word.
- clear  input  1  synchronous flush.
- push_ack  output  1  push accepted this cycle; word is written.
- pop_ack  output  1  pop accepted this cycle; memory DataOut holds the head word this cycle.
- RowSelect  output  Column  one-hot row select to the memory block.
- WriteEn  output  1  write strobe to the memory block.
- full  output  1  count == Column.
- empty  output  1  count == 0.
- count  output  clog2(Column+1)  current occupancy.
- overflow  output  1  sticky: push seen while full.
- underflow  output  1  sticky: pop seen while empty.

Behaviour:
- State registers: wr_ptr, rd_ptr (clog2(Column) bits), count, last_push (1 = push won the most recent conflict), overflow, underflow.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, last_push=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, push_ack=0, pop_ack=0, WriteEn=0, RowSelect=onehot(0).
- Reset asserted mid-operation discards all contents immediately. No write may be issued while rst=1.
- Eligibility: push_req = push & ~full; pop_req = pop & ~empty.
- Grant (combinational, same cycle):
  - only push_req: grant push.
  - only pop_req: grant pop.
  - both requested: grant pop if last_push=1, else grant push.
  - last_push updates only on a conflict cycle.
  - Exactly one or zero grants per cycle.
- Outputs:
  - push_ack = WriteEn = push granted.
  - pop_ack = pop granted.
  - RowSelect = onehot(wr_ptr) when push granted, else onehot(rd_ptr). The head word is therefore visible on DataOut whenever the controller is not writing.
  - All outputs are combinational from registered state plus push/pop/clear; no added latency.
- On clock edge:
  - push granted: wr_ptr advances (wraps Column-1 -> 0), count+1.
  - pop granted: rd_ptr advances (same wrap rule), count-1.
  - A word written in cycle N is poppable from cycle N+1.
- full/empty/count are registered-state derived. Zero-latency full->empty transitions are impossible: one op per cycle.
- The un-granted requester simply retries; requesters hold push/pop until ack.
- Error flags:
  - push & full sets overflow; pop & empty sets underflow.
  - Both are sticky until rst or clear.
  - The request is ignored with no ack and no state change.
- clear: on the edge, pointers, count, last_push and the sticky flags return to their reset values. While clear=1, grants and WriteEn are forced to 0. clear has priority over push/pop in that cycle.
- Non-power-of-two Column: pointer wrap is by compare to Column-1, never by natural overflow.

Decomposition:
- Package queue_pkg:
  - PTR_W = clog2(Column) and CNT_W = clog2(Column+1) helper functions.
  - onehot(index) function returning Column bits.
  - grant encoding constants (GNT_NONE, GNT_PUSH, GNT_POP).
- One sub-module, queue_ptr: a wrap-around pointer register with inc and clear, async rst. Instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Reset then idle, Column=4: empty=1, full=0, count=0, RowSelect=0001, WriteEn=0, acks 0.
- Four pushes, one per cycle: WriteEn pulses with RowSelect 0001, 0010, 0100, 1000. Then full=1, count=4. A fifth push gives push_ack=0 and overflow=1.
- Pop four times: pop_ack each cycle with RowSelect 0001..1000, then empty=1. A fifth pop gives underflow=1. Push 8 more words while popping to cover wrap: pointers return to 0 and no slot is lost.
- push=pop=1 held with count=2: grants alternate push, pop, push, pop (last_push reset 0, so push first). count oscillates 3, 2, 3, 2.
- clear asserted with count=3 and overflow=1: next cycle count=0, empty=1, overflow=0, RowSelect=0001, no WriteEn during the clear cycle.
- rst pulsed asynchronously between edges with count=2: outputs return to reset values immediately without waiting for clk. A subsequent push writes row 0001.
